// File: rtl/branch_redirect_ctrl.sv
// Resolved-branch redirect controller: registered PC redirect, multi-cycle flush, return-address stack.
// Optional BRANCH_STATS_EN enables redirect / squashed-resolve counters (ports are tied to 0 otherwise).
module branch_redirect_ctrl #(
  parameter int ADDR_W       = 10,
  parameter int RAS_DEPTH    = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              res_valid_i,
  input  logic [3:0]        branch_type_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] target_addr_i,
  input  logic [ADDR_W-1:0] ret_addr_i,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              flush_o,
  output logic              busy_o,
  output logic              i_set_o,
  output logic              i_clr_o,
  output logic              ras_ovf_o,
  output logic              ras_unf_o,
  output logic [15:0]       redir_cnt_o,
  output logic [15:0]       squash_cnt_o
);
  localparam int PW = $clog2(RAS_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REDIR, S_FLUSH} state_e;

  state_e            state_q;
  logic [3:0]        fcnt_q;
  logic              redirect_q, flush_q, busy_q, iset_q, iclr_q, ovf_q, unf_q;
  logic [ADDR_W-1:0] pc_q;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  logic              is_cond, is_call, is_ret, accept, push, pop;
  logic              stack_empty, stack_full;
  logic [ADDR_W-1:0] pop_pc;

  always_comb begin
    is_cond     = (branch_type_i >= 4'd1) && (branch_type_i <= 4'd5);
    is_call     = (branch_type_i == 4'd6);
    is_ret      = (branch_type_i >= 4'd7) && (branch_type_i <= 4'd9);
    accept      = (state_q == S_IDLE) && res_valid_i &&
                  (((is_cond || is_ret) && branch_taken_i) || is_call);
    push        = accept && is_call;
    pop         = accept && is_ret;
    stack_empty = (cnt_q == '0);
    stack_full  = (cnt_q == (PW+1)'(RAS_DEPTH));
    pop_pc      = stack_empty ? '0 : ras_q[ptr_q - PW'(1)];
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    // A full push overwrites the oldest entry, so the pointer still advances.
    if (push) begin
      ptr_d = ptr_q + PW'(1);
      cnt_d = stack_full ? cnt_q : cnt_q + (PW+1)'(1);
    end else if (pop && !stack_empty) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      fcnt_q     <= '0;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
      iset_q     <= 1'b0;
      iclr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      pc_q       <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      redirect_q <= 1'b0;
      iset_q     <= 1'b0;
      iclr_q     <= 1'b0;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      if (push && stack_full)  ovf_q <= 1'b1;
      if (pop && stack_empty)  unf_q <= 1'b1;
      case (state_q)
        S_IDLE: if (accept) begin
          state_q    <= S_REDIR;
          redirect_q <= 1'b1;
          flush_q    <= 1'b1;
          busy_q     <= 1'b1;
          pc_q       <= is_ret ? pop_pc : target_addr_i;
          iclr_q     <= (branch_type_i == 4'd8);
          iset_q     <= (branch_type_i == 4'd9);
        end
        S_REDIR: if (FLUSH_CYCLES == 1) begin
          state_q <= S_IDLE;
          flush_q <= 1'b0;
          busy_q  <= 1'b0;
        end else begin
          state_q <= S_FLUSH;
          fcnt_q  <= 4'(FLUSH_CYCLES - 2);
        end
        S_FLUSH: if (fcnt_q == '0) begin
          state_q <= S_IDLE;
          flush_q <= 1'b0;
          busy_q  <= 1'b0;
        end else begin
          fcnt_q <= fcnt_q - 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) ras_q[ptr_q] <= ret_addr_i;
  end

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = pc_q;
  assign flush_o       = flush_q;
  assign busy_o        = busy_q;
  assign i_set_o       = iset_q;
  assign i_clr_o       = iclr_q;
  assign ras_ovf_o     = ovf_q;
  assign ras_unf_o     = unf_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] redir_cnt_q, squash_cnt_q;
  logic        squash;

  assign squash = res_valid_i && (state_q != S_IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      redir_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (accept && redir_cnt_q != 16'hFFFF)  redir_cnt_q  <= redir_cnt_q + 16'd1;
      if (squash && squash_cnt_q != 16'hFFFF) squash_cnt_q <= squash_cnt_q + 16'd1;
    end
  end

  assign redir_cnt_o  = redir_cnt_q;
  assign squash_cnt_o = squash_cnt_q;
`else
  assign redir_cnt_o  = '0;
  assign squash_cnt_o = '0;
`endif
endmodule
